// File: rtl/exp_fsmd_param.sv
// Exponent FSMD: result_o = a_i ** n_i mod 2**WIDTH, with a sticky overflow flag and a go/done handshake.
// Define FAST_EXP_EN for LSB-first square-and-multiply; by default the exponent is worked off one multiply per cycle.
module exp_fsmd_param #(
    parameter int WIDTH     = 6,
    parameter int EXP_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [EXP_WIDTH-1:0] n_i,
    output logic [WIDTH-1:0]     result_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 ovf_o,
    output logic [1:0]           state_o
);

    // Handshake: go_i is a level request sampled only in IDLE. The sampling edge
    // captures a_i/n_i and raises busy_o. done_o pulses for one cycle on the edge
    // that updates result_o/ovf_o. The FSM then waits in HOLD until go_i drops,
    // so a held go_i produces exactly one run.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     base_q;
    logic [EXP_WIDTH-1:0] n_q;
    logic                 ovf_acc_q;
    logic [WIDTH-1:0]     result_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 ovf_q;

    logic [2*WIDTH-1:0]   mul_full;

    always_comb begin
        mul_full = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
    end

`ifdef FAST_EXP_EN
    logic               base_ovf_q;
    logic [2*WIDTH-1:0] sq_full;

    always_comb begin
        sq_full = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
            base_q    <= '0;
            n_q       <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef FAST_EXP_EN
            base_ovf_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (go_i) begin
                        acc_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
                        base_q    <= a_i;
                        n_q       <= n_i;
                        ovf_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef FAST_EXP_EN
                        base_ovf_q <= 1'b0;
`endif
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (n_q == '0) begin
                        result_q <= acc_q;
                        ovf_q    <= ovf_acc_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_HOLD;
                    end else begin
`ifdef FAST_EXP_EN
                        // A squared base that overflowed only matters once it is multiplied in.
                        if (n_q[0]) begin
                            acc_q     <= mul_full[WIDTH-1:0];
                            ovf_acc_q <= ovf_acc_q | (|mul_full[2*WIDTH-1:WIDTH]) | base_ovf_q;
                        end
                        base_q     <= sq_full[WIDTH-1:0];
                        base_ovf_q <= base_ovf_q | (|sq_full[2*WIDTH-1:WIDTH]);
                        n_q        <= n_q >> 1;
`else
                        acc_q     <= mul_full[WIDTH-1:0];
                        ovf_acc_q <= ovf_acc_q | (|mul_full[2*WIDTH-1:WIDTH]);
                        n_q       <= n_q - {{(EXP_WIDTH-1){1'b0}}, 1'b1};
`endif
                    end
                end
                S_HOLD: begin
                    done_q <= 1'b0;
                    if (!go_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign ovf_o    = ovf_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_exp_fsmd_param.sv
// Self-checking bench for exp_fsmd_param (WIDTH=6, EXP_WIDTH=6): vector table plus handshake/reset sequences.
module tb_exp_fsmd_param;

    logic       clk;
    logic       rst;
    logic       go_i;
    logic [5:0] a_i;
    logic [5:0] n_i;
    logic [5:0] result_o;
    logic       done_o;
    logic       busy_o;
    logic       ovf_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    exp_fsmd_param #(.WIDTH(6), .EXP_WIDTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .go_i     (go_i),
        .a_i      (a_i),
        .n_i      (n_i),
        .result_o (result_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .ovf_o    (ovf_o),
        .state_o  (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [5:0] n;
        logic [5:0] res;
        logic       ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int n);
        int bl;
`ifdef FAST_EXP_EN
        bl = 0;
        while ((n >> bl) != 0) bl++;
        return bl + 1;
`else
        bl = n;
        return bl + 1;
`endif
    endfunction

    // driver: present operands and hold go_i across one rising edge
    task automatic start_run(input logic [5:0] a, input logic [5:0] n);
        @(negedge clk);
        a_i  = a;
        n_i  = n;
        go_i = 1'b1;
        @(posedge clk);
        #1;
        go_i = 1'b0;
        chk("start_busy", int'(busy_o), 1);
        chk("start_state", int'(state_o), 1);
    endtask

    // wait for done_o (bounded), watching busy_o and result stability; optionally disturb inputs mid-run
    task automatic wait_done(input logic [5:0] prev, input int disturb_at,
                             output int lat, output bit stable_ok);
        lat = 0;
        stable_ok = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_o) break;
            if (!busy_o || result_o !== prev) stable_ok = 1'b0;
            if (lat == disturb_at) begin
                a_i  = 6'd5;
                n_i  = 6'd1;
                go_i = 1'b1;
            end else if (lat == disturb_at + 1) begin
                go_i = 1'b0;
            end
        end
    endtask

    // scoreboard: one full run checked against hand-computed expectations
    task automatic run_vec(input string tag, input logic [5:0] a, input logic [5:0] n,
                           input logic [5:0] res, input logic ovf, input int disturb_at);
        int lat;
        bit stable_ok;
        logic [5:0] prev;
        prev = result_o;
        start_run(a, n);
        wait_done(prev, disturb_at, lat, stable_ok);
        chk({tag, "_latency"}, lat, exp_latency(int'(n)));
        chk({tag, "_stable_busy"}, int'(stable_ok), 1);
        chk({tag, "_result"}, int'(result_o), int'(res));
        chk({tag, "_ovf"}, int'(ovf_o), int'(ovf));
        chk({tag, "_busy_done"}, int'(busy_o), 0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, int'(done_o), 0);
        chk({tag, "_back_idle"}, int'(state_o), 0);
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{6'd3,  6'd3,  6'd27, 1'b0};
        vecs[1]  = '{6'd2,  6'd6,  6'd0,  1'b1};
        vecs[2]  = '{6'd5,  6'd0,  6'd1,  1'b0};
        vecs[3]  = '{6'd0,  6'd0,  6'd1,  1'b0};
        vecs[4]  = '{6'd0,  6'd5,  6'd0,  1'b0};
        vecs[5]  = '{6'd1,  6'd63, 6'd1,  1'b0};
        vecs[6]  = '{6'd2,  6'd5,  6'd32, 1'b0};
        vecs[7]  = '{6'd7,  6'd2,  6'd49, 1'b0};
        vecs[8]  = '{6'd8,  6'd2,  6'd0,  1'b1};
        vecs[9]  = '{6'd63, 6'd1,  6'd63, 1'b0};
        vecs[10] = '{6'd63, 6'd2,  6'd1,  1'b1};
        vecs[11] = '{6'd3,  6'd4,  6'd17, 1'b1};
        vecs[12] = '{6'd5,  6'd3,  6'd61, 1'b1};
        vecs[13] = '{6'd2,  6'd63, 6'd0,  1'b1};
        vecs[14] = '{6'd7,  6'd3,  6'd23, 1'b1};

        rst  = 1'b1;
        go_i = 1'b0;
        a_i  = 6'd0;
        n_i  = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", int'(result_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        chk("rst_state", int'(state_o), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].n, vecs[i].res, vecs[i].ovf, -1);
        end

        // held go_i: exactly one run
        pulses = 0;
        @(negedge clk);
        a_i  = 6'd2;
        n_i  = 6'd2;
        go_i = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_result", int'(result_o), 4);
        chk("hold_state", int'(state_o), 2);
        go_i = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_release_idle", int'(state_o), 0);
        run_vec("after_hold", 6'd7, 6'd2, 6'd49, 1'b0, -1);

        // reset on the 4th CALC cycle of a long run
        start_run(6'd3, 6'd10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_result", int'(result_o), 0);
        chk("midrst_ovf", int'(ovf_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_state", int'(state_o), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        run_vec("after_rst", 6'd3, 6'd3, 6'd27, 1'b0, -1);

        // operand change and go pulse mid-run are ignored
        run_vec("disturb", 6'd3, 6'd3, 6'd27, 1'b0, 2);
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) pulses++;
        end
        chk("disturb_no_rerun", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_fsmd_param.md
Name: exp_fsmd_param

Overview:
- Parametrised exponent FSMD. Computes result = a^n mod 2^WIDTH with a go/done handshake.
- Successor to the fixed 6-bit exponent engine. Adds configurable operand widths, a busy indicator, overflow detection and an optional square-and-multiply mode.
- Sits between the operand inputs and the LCD display controller. done_o drives the controller's start; result_o drives its result value.

Parameters:
- WIDTH, 6, bit width of base a_i and result_o (>=2).
- EXP_WIDTH, 6, bit width of exponent n_i (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- go_i  input  1  start request, level-sensitive.
- a_i  input  WIDTH  base operand; sampled only at start.
- n_i  input  EXP_WIDTH  exponent operand; sampled only at start.
- result_o  output  WIDTH  a^n truncated to WIDTH bits; holds until the next completion.
- done_o  output  1  one-cycle pulse when result_o/ovf_o update.
- busy_o  output  1  high while a computation is in progress.
- ovf_o  output  1  high if the true a^n does not fit in WIDTH bits.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: result_o=0, done_o=0, busy_o=0, ovf_o=0, state=IDLE. Internal acc=1, base=0, n_reg=0, ovf_acc=0, base_ovf=0.
- States: IDLE, CALC, HOLD.
- IDLE, go_i=1:
  - acc<=1, base<=a_i, n_reg<=n_i, ovf_acc<=0, base_ovf<=0, busy_o<=1.
  - Next state CALC.
- IDLE, go_i=0: stay in IDLE.
- CALC, n_reg==0:
  - result_o<=acc, ovf_o<=ovf_acc, done_o<=1, busy_o<=0.
  - Next state HOLD.
- CALC, n_reg!=0 (default, repeated multiply):
  - Form the full 2*WIDTH product acc*base.
  - acc<=low WIDTH bits of the product.
  - ovf_acc<=ovf_acc | (upper WIDTH bits != 0).
  - n_reg<=n_reg-1.
- HOLD:
  - done_o<=0.
  - Return to IDLE when go_i==0; stay in HOLD while go_i==1. A held go_i yields exactly one run.
- done_o is high for exactly one cycle per run; it is 0 in every other cycle.
- Latency (default mode): done_o is visible after the (n+1)th rising edge following the edge that sampled go_i. Example: n=0 gives 1 edge; n=3 gives 4 edges.
- go_i asserted while busy_o=1 or in HOLD is ignored. a_i/n_i changes after the start edge have no effect.
- result_o and ovf_o change only on the completion edge, so the previous result stays stable during a run.
- n=0 → result 1, ovf 0, for any a (including a=0).
- a=0 with n>0 → result 0, ovf 0.
- a=1 → result 1, ovf 0, for any n.
- rst asserted in any state, including mid-CALC: all outputs return to reset values on that edge, and no done_o pulse is produced.

Optional Feature:
- Macro: FAST_EXP_EN.
- Defined: CALC uses LSB-first square-and-multiply. Per cycle with n_reg!=0:
  - If n_reg[0]==1: acc<=low(acc*base); ovf_acc |= upper bits nonzero, or base_ovf==1.
  - base<=low(base*base); base_ovf |= upper bits of the square nonzero.
  - n_reg<=n_reg>>1.
- FAST_EXP_EN latency: done_o after (bit-length of n)+1 edges; n=0 gives 1 edge.
- A base overflow that is never multiplied into acc does not set ovf_o.
- Undefined: repeated multiply only. No base_ovf register, no squaring multiplier.
- result_o and ovf_o are identical in both modes for all inputs; only latency differs.

Test Plan:
1. WIDTH=6: a=3, n=3, go_i pulse → result_o=27, ovf_o=0; done_o 1-cycle pulse 4 edges after start; busy_o high for the intervening cycles.
2. a=2, n=6 → result_o=0, ovf_o=1. Then a=5, n=0 → result_o=1, ovf_o=0 after 1 edge. Then a=0, n=0 → result_o=1.
3. Hold go_i high for 20 cycles with a=2, n=2 → exactly one done_o pulse, result_o=4. Drop go_i, re-assert with a=7, n=2 → result_o=49, ovf_o=0.
4. Start a=3, n=10; assert rst on the 4th CALC cycle → busy_o=0, result_o=0, ovf_o=0; no done_o pulse; go_i afterwards starts a clean run.
5. Change a_i/n_i and pulse go_i mid-run (a=3, n=3) → result 27 is unaffected; no second run starts.
6. FAST_EXP_EN defined: a=2, n=5 → result_o=32, ovf_o=0 (unused base square 256 is ignored), done_o after 4 edges. a=3, n=3 → 27 after 3 edges. a=2, n=6 → 0, ovf_o=1.
